contactor_sequencer: RTL
========================

# contactor_sequencer

Pack contactor sequencer: consumes the registered `soa_violation` flag from the safe-operating-area monitor, drives the negative contactor, precharge relay and positive main contactor through a timed close sequence, and opens everything on a debounced violation. It sits between the protection monitors and the contactor driver pins. A latched fault holds all contactors open until an explicit host clear with the violation gone.

## Interface
- `PRECHARGE_TIMEOUT`, 16'd5000: maximum cycles allowed in PRECHARGE for the bus to reach `bus_v_ok`.
- `OVERLAP_CYCLES`, 8'd10: cycles the precharge relay stays closed after the main contactor closes. Legal range 1..255.
- `DEBOUNCE`, 4'd3: consecutive high samples of `soa_violation` needed to trip. Legal range 1..15.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `soa_violation` input 1: active-high SOA violation from the monitor.
- `close_req` input 1: host request to close the pack (level or pulse, sampled each cycle).
- `open_req` input 1: host request to open the pack.
- `fault_clear` input 1: host request to clear a latched fault.
- `bus_v_ok` input 1: bus voltage has reached the precharge threshold.
- `neg_contactor` output 1: 1 = negative contactor closed.
- `precharge_relay` output 1: 1 = precharge relay closed.
- `pos_contactor` output 1: 1 = positive main contactor closed.
- `fault_latched` output 1: 1 while in FAULT.
- `fault_code` output 2: 00 none, 01 SOA trip, 10 precharge timeout.
- `state_code` output 3: IDLE=0, PRECHARGE=1, CLOSE_MAIN=2, RUN=3, FAULT=4.

## Operation
- **Outputs are Moore.** They are decoded from the state register. `fault_code` is a register. There is no combinational input-to-output path.
- **Output decode per state:**
  - IDLE: all contactors open.
  - PRECHARGE: neg=1, pre=1, pos=0.
  - CLOSE_MAIN: neg=1, pre=1, pos=1.
  - RUN: neg=1, pre=0, pos=1.
  - FAULT: all open, `fault_latched`=1.
- **Debounce counter (4-bit, saturating at `DEBOUNCE`).**
  - Increments each cycle `soa_violation`=1.
  - Clears to 0 on any cycle `soa_violation`=0.
  - It runs in every state, including IDLE and FAULT.
  - A trip occurs when the counter would reach `DEBOUNCE` on the current sample.
- **Timer (16-bit).** Clears on entry to PRECHARGE and on entry to CLOSE_MAIN, and increments each cycle in those states.
- **Transitions, highest priority first. Every state obeys this order:**
  1. `rst` forces IDLE, clears all counters, and sets `fault_code`=00.
  2. A trip moves any non-FAULT state to FAULT with `fault_code`=01. A trip while already in FAULT keeps the existing code.
  3. PRECHARGE with `bus_v_ok`=1 moves to CLOSE_MAIN. This wins over a timeout in the same cycle.
  4. PRECHARGE with timer == `PRECHARGE_TIMEOUT`-1 and `bus_v_ok`=0 moves to FAULT with `fault_code`=10.
  5. PRECHARGE, CLOSE_MAIN or RUN with `open_req`=1 moves to IDLE.
  6. IDLE with `close_req`=1 and `open_req`=0 moves to PRECHARGE.
  7. CLOSE_MAIN with timer == `OVERLAP_CYCLES`-1 moves to RUN.
  8. FAULT with `fault_clear`=1, `soa_violation`=0 and debounce counter 0 moves to IDLE and sets `fault_code`=00. A `close_req` in the same cycle is ignored, so a fresh `close_req` is required.
- **Other rules:**
  - `close_req` outside IDLE is ignored.
  - `bus_v_ok` outside PRECHARGE is ignored.
  - Dropping `bus_v_ok` in RUN does not open the pack; that is the monitors' job.

## Timing
- **Reset value:** state IDLE, all contactors 0, `fault_latched`=0, `fault_code`=00, `state_code`=0. Reset mid-sequence opens all contactors at the next edge.
- **Close latency:** `close_req` sampled at edge n gives PRECHARGE outputs after edge n.
- **Precharge duration:**
  - Lasts until the edge that samples `bus_v_ok`=1.
  - Never exceeds `PRECHARGE_TIMEOUT` cycles.
  - On timeout, outputs open after the `PRECHARGE_TIMEOUT`-th edge in PRECHARGE.
- **Overlap:** CLOSE_MAIN lasts exactly `OVERLAP_CYCLES` cycles, then RUN.
- **Trip latency:** with `soa_violation` high from edge k, FAULT and all-open take effect after edge k+`DEBOUNCE`-1. A one-cycle glitch shorter than `DEBOUNCE` has no effect.
- **Open latency:** `open_req` opens all contactors after the sampling edge.
- **Fault clear:** takes effect one edge after the sample that meets all clear conditions.

## Test plan
Parameters for all scenarios: `PRECHARGE_TIMEOUT`=20, `OVERLAP_CYCLES`=4, `DEBOUNCE`=3.
- **Nominal close:** `close_req` pulse at cycle 0, `bus_v_ok` rises at cycle 6 → `state_code` sequence 0,1×6 cycles,2×4 cycles,3. `pos_contactor` high from cycle 7. `precharge_relay` low from cycle 11.
- **Precharge timeout:** `close_req`, `bus_v_ok` held 0 → FAULT after exactly 20 PRECHARGE cycles, `fault_code`=10, all contactors 0. `bus_v_ok`=1 on cycle 20 instead → CLOSE_MAIN, no fault.
- **Debounce:** in RUN, `soa_violation` high 2 cycles then low → stays RUN. High 3 cycles → FAULT after the 3rd edge, `fault_code`=01, all contactors 0.
- **Clear gating:**
  - `fault_clear` while `soa_violation`=1 → remains FAULT.
  - Violation low, then `fault_clear` together with `close_req` → IDLE, not PRECHARGE.
  - A later `close_req` → PRECHARGE.
- **Priority collisions:**
  - `open_req` and a trip in the same cycle in RUN → FAULT, not IDLE.
  - `open_req` during CLOSE_MAIN → IDLE next cycle with all contactors 0.
- **Reset mid-sequence:** `rst` asserted during CLOSE_MAIN → next edge all outputs 0, `state_code`=0, `fault_code`=00. After reset, debounce restarts, so 2 violation samples do not trip.

Source files
------------

// File: rtl/contactor_sequencer.sv
// Pack contactor sequencer: timed close of negative, precharge and positive contactors,
// with debounced SOA trip and precharge timeout latched into FAULT until a host clear.
module contactor_sequencer #(
  parameter logic [15:0] PRECHARGE_TIMEOUT = 16'd5000,
  parameter logic [7:0]  OVERLAP_CYCLES    = 8'd10,
  parameter logic [3:0]  DEBOUNCE          = 4'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soa_violation,
  input  logic       close_req,
  input  logic       open_req,
  input  logic       fault_clear,
  input  logic       bus_v_ok,
  output logic       neg_contactor,
  output logic       precharge_relay,
  output logic       pos_contactor,
  output logic       fault_latched,
  output logic [1:0] fault_code,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRECHARGE  = 3'd1,
    ST_CLOSE_MAIN = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_SOA     = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  state_t      state, state_next;
  logic [3:0]  deb_cnt, deb_next;
  logic        trip;
  logic [15:0] timer, timer_next;
  logic [1:0]  fault_code_next;
  logic        timed_state;

  // Saturating debounce; trip fires on the sample that brings the count to DEBOUNCE.
  always_comb begin
    deb_next = 4'd0;
    if (soa_violation) begin
      deb_next = (deb_cnt >= DEBOUNCE) ? DEBOUNCE : deb_cnt + 4'd1;
    end
    trip = soa_violation && (deb_next == DEBOUNCE);
  end

  always_comb begin
    state_next      = state;
    fault_code_next = fault_code;
    if (trip && state != ST_FAULT) begin
      state_next      = ST_FAULT;
      fault_code_next = FC_SOA;
    end else begin
      case (state)
        ST_IDLE: begin
          if (close_req && !open_req) state_next = ST_PRECHARGE;
        end
        ST_PRECHARGE: begin
          if (bus_v_ok) begin
            state_next = ST_CLOSE_MAIN;
          end else if (timer == PRECHARGE_TIMEOUT - 16'd1) begin
            state_next      = ST_FAULT;
            fault_code_next = FC_TIMEOUT;
          end else if (open_req) begin
            state_next = ST_IDLE;
          end
        end
        ST_CLOSE_MAIN: begin
          if (open_req) begin
            state_next = ST_IDLE;
          end else if (timer == {8'd0, OVERLAP_CYCLES} - 16'd1) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (open_req) state_next = ST_IDLE;
        end
        ST_FAULT: begin
          // Clear lands in IDLE even with close_req high; a new request is needed.
          if (fault_clear && !soa_violation && deb_cnt == 4'd0) begin
            state_next      = ST_IDLE;
            fault_code_next = FC_NONE;
          end
        end
        default: begin
          state_next      = ST_IDLE;
          fault_code_next = FC_NONE;
        end
      endcase
    end
  end

  assign timed_state = (state == ST_PRECHARGE) || (state == ST_CLOSE_MAIN);

  always_comb begin
    timer_next = timer;
    if (state_next != state &&
        (state_next == ST_PRECHARGE || state_next == ST_CLOSE_MAIN)) begin
      timer_next = 16'd0;
    end else if (timed_state) begin
      timer_next = timer + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      deb_cnt    <= 4'd0;
      timer      <= 16'd0;
      fault_code <= FC_NONE;
    end else begin
      state      <= state_next;
      deb_cnt    <= deb_next;
      timer      <= timer_next;
      fault_code <= fault_code_next;
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    neg_contactor   = 1'b0;
    precharge_relay = 1'b0;
    pos_contactor   = 1'b0;
    fault_latched   = 1'b0;
    case (state)
      ST_PRECHARGE: begin
        neg_contactor   = 1'b1;
        precharge_relay = 1'b1;
      end
      ST_CLOSE_MAIN: begin
        neg_contactor   = 1'b1;
        precharge_relay = 1'b1;
        pos_contactor   = 1'b1;
      end
      ST_RUN: begin
        neg_contactor = 1'b1;
        pos_contactor = 1'b1;
      end
      ST_FAULT: fault_latched = 1'b1;
      default: ;
    endcase
  end

  assign state_code = state;

endmodule
